// File: rtl/nrdiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// nrdiv_seq_ctrl
//   Sequencer for an unsigned non-restoring divider. It runs one shift and
//   add-or-subtract iteration per clock through a single N+1-bit adder, then
//   does one remainder-restore cycle. The result is held until the consumer
//   takes it.
//
//   Operands are taken over a valid/ready handshake. Results are delivered
//   over a valid/ready handshake. Accept and deliver never overlap.
//
//   Optional build macro:
//     NRDIV_EARLY_DBZ_EN - when defined, an accept with divisor==0 goes
//                          straight to DONE with the divide-by-zero result.
//                          When undefined, it takes the normal iteration path
//                          and ends with the same result values.
//
// Parameters
//   N   operand width (2..32)
//   CW  iteration counter width (derived)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   dividend, divisor     unsigned operands, sampled on the accept edge only
//   out_valid / out_ready result handshake; out_valid holds until accepted
//   quotient, remainder   result; held until the next restore cycle
//   div_by_zero           divisor was zero for the current result
//   busy                  controller is in any state other than IDLE
// ---------------------------------------------------------------------------
module nrdiv_seq_ctrl #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N:0]    a;      // signed partial remainder
    logic [N-1:0]  q;
    logic [N-1:0]  yr;
    logic [CW-1:0] cnt;
    logic          dbz;

    logic [N:0]    y_ext;
    logic [N:0]    a_sh;
    logic [N:0]    a_it;
    logic [N:0]    a_rs;

    // One shared add/sub path. The sign of the pre-shift partial remainder
    // selects add or subtract. Intermediate overflow of the shifted value
    // wraps harmlessly mod 2^(N+1), because the post-op value always lies in
    // [-Y, Y).
    always_comb begin
        y_ext = {1'b0, yr};
        a_sh  = {a[N-1:0], q[N-1]};
        a_it  = a[N] ? (a_sh + y_ext) : (a_sh - y_ext);
        a_rs  = a[N] ? (a + y_ext) : a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            yr          <= '0;
            cnt         <= '0;
            dbz         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a        <= '0;
                        q        <= dividend;
                        yr       <= divisor;
                        cnt      <= '0;
                        dbz      <= (divisor == '0);
                        state    <= ITER;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef NRDIV_EARLY_DBZ_EN
                        // Bypass the iterations. The result is the same one
                        // the full path would produce for a zero divisor.
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end
`endif
                    end
                end

                ITER: begin
                    a   <= a_it;
                    q   <= {q[N-2:0], ~a_it[N]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= RESTORE;
                end

                // Always taken, even when the partial remainder is already
                // non-negative, so that latency stays fixed.
                RESTORE: begin
                    a           <= a_rs;
                    quotient    <= q;
                    remainder   <= a_rs[N-1:0];
                    div_by_zero <= dbz;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nrdiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nrdiv_seq_ctrl
//   Directed and exhaustive checks of nrdiv_seq_ctrl at N=4.
// ---------------------------------------------------------------------------
module tb_nrdiv_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

`ifdef NRDIV_EARLY_DBZ_EN
    localparam int DBZ_LAT = 1;
`else
    localparam int DBZ_LAT = 6;
`endif

    nrdiv_seq_ctrl #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue one operation, wait for the result, stall out_ready for 'stall'
    // cycles, then complete the handshake. 'lat' counts rising edges from the
    // accept edge (counted as 1) to the first edge after which out_valid is
    // seen high.
    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input int stall,
                          output logic [3:0] qo, output logic [3:0] ro, output logic dz,
                          output int lat, output bit timeout);
        int g;
        timeout = 1'b0;
        lat = 0;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) timeout = 1'b1;
        in_valid = 1'b1;
        dividend = x;
        divisor  = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 4'($urandom);   // later operand changes must not matter
        divisor  = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        qo = quotient;
        ro = remainder;
        dz = div_by_zero;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %0b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rel_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (quotient !== 4'd0) $display("FAIL rel_quotient got %0d want 0", quotient); else n_pass++;
        n_total++; if (remainder !== 4'd0) $display("FAIL rel_remainder got %0d want 0", remainder); else n_pass++;
        n_total++; if (div_by_zero !== 1'b0) $display("FAIL rel_dbz got %0b want 0", div_by_zero); else n_pass++;
    endtask

    task automatic test_basic();
        logic [3:0] qo, ro;
        logic dz;
        int lat;
        bit to;
        run_op(4'd13, 4'd3, 0, qo, ro, dz, lat, to);
        n_total++; if (to) $display("FAIL b13_3_timeout got timeout want result"); else n_pass++;
        n_total++; if (qo !== 4'd4) $display("FAIL b13_3_q got %0d want 4", qo); else n_pass++;
        n_total++; if (ro !== 4'd1) $display("FAIL b13_3_r got %0d want 1", ro); else n_pass++;
        n_total++; if (dz !== 1'b0) $display("FAIL b13_3_dbz got %0b want 0", dz); else n_pass++;
        n_total++; if (lat != 6) $display("FAIL b13_3_latency got %0d want 6", lat); else n_pass++;
        run_op(4'd15, 4'd1, 0, qo, ro, dz, lat, to);
        n_total++; if (qo !== 4'd15) $display("FAIL b15_1_q got %0d want 15", qo); else n_pass++;
        n_total++; if (ro !== 4'd0) $display("FAIL b15_1_r got %0d want 0", ro); else n_pass++;
        n_total++; if (lat != 6) $display("FAIL b15_1_latency got %0d want 6", lat); else n_pass++;
        run_op(4'd2, 4'd5, 0, qo, ro, dz, lat, to);
        n_total++; if (qo !== 4'd0) $display("FAIL b2_5_q got %0d want 0", qo); else n_pass++;
        n_total++; if (ro !== 4'd2) $display("FAIL b2_5_r got %0d want 2", ro); else n_pass++;
        n_total++; if (dz !== 1'b0) $display("FAIL b2_5_dbz got %0b want 0", dz); else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [3:0] qo, ro;
        logic dz;
        int lat;
        bit to;
        run_op(4'd7, 4'd0, 0, qo, ro, dz, lat, to);
        n_total++; if (to) $display("FAIL dbz_timeout got timeout want result"); else n_pass++;
        n_total++; if (qo !== 4'd15) $display("FAIL dbz_q got %0d want 15", qo); else n_pass++;
        n_total++; if (ro !== 4'd7) $display("FAIL dbz_r got %0d want 7", ro); else n_pass++;
        n_total++; if (dz !== 1'b1) $display("FAIL dbz_flag got %0b want 1", dz); else n_pass++;
        n_total++; if (lat != DBZ_LAT) $display("FAIL dbz_latency got %0d want %0d", lat, DBZ_LAT); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [3:0] qo, ro;
        logic dz;
        int lat;
        bit to;
        @(negedge clk);
        in_valid = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++; if (lat != 6) $display("FAIL bp_latency got %0d want 6", lat); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = 4'd6; divisor = 4'd3; out_ready = 1'b0;
            @(posedge clk); #1;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %0b want 1", k, out_valid); else n_pass++;
            n_total++; if (quotient !== 4'd4) $display("FAIL bp_hold_q[%0d] got %0d want 4", k, quotient); else n_pass++;
            n_total++; if (remainder !== 4'd1) $display("FAIL bp_hold_r[%0d] got %0d want 1", k, remainder); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b want 0", k, in_ready); else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL bp_release_busy got %0b want 0", busy); else n_pass++;
        run_op(4'd6, 4'd3, 0, qo, ro, dz, lat, to);
        n_total++; if (qo !== 4'd2) $display("FAIL bp_next_q got %0d want 2", qo); else n_pass++;
        n_total++; if (ro !== 4'd0) $display("FAIL bp_next_r got %0d want 0", ro); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [3:0] qo, ro;
        logic dz;
        int lat;
        bit to;
        @(negedge clk);
        in_valid = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL mr_busy got %0b want 1", busy); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mr_busy_rst got %0b want 0", busy); else n_pass++;
        n_total++; if (quotient !== 4'd0) $display("FAIL mr_quotient got %0d want 0", quotient); else n_pass++;
        n_total++; if (remainder !== 4'd0) $display("FAIL mr_remainder got %0d want 0", remainder); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mr_in_ready got %0b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mr_no_result got %0b want 0", out_valid); else n_pass++;
        run_op(4'd14, 4'd3, 0, qo, ro, dz, lat, to);
        n_total++; if (qo !== 4'd4) $display("FAIL mr_next_q got %0d want 4", qo); else n_pass++;
        n_total++; if (ro !== 4'd2) $display("FAIL mr_next_r got %0d want 2", ro); else n_pass++;
    endtask

    task automatic test_exhaustive();
        logic [3:0] qo, ro, eq, er;
        logic dz, edz;
        int lat;
        bit to;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(4'(x), 4'(y), int'($urandom_range(0, 3)), qo, ro, dz, lat, to);
                if (y == 0) begin
                    eq = 4'd15; er = 4'(x); edz = 1'b1;
                end else begin
                    eq = 4'(x / y); er = 4'(x % y); edz = 1'b0;
                end
                n_total++;
                if (to || qo !== eq || ro !== er || dz !== edz)
                    $display("FAIL ex_%0d_%0d got q=%0d r=%0d dbz=%0b to=%0b want q=%0d r=%0d dbz=%0b",
                             x, y, qo, ro, dz, to, eq, er, edz);
                else
                    n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_mid_reset();
        test_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
